// File: rtl/self_test_rx_pkg.sv
// Shared definitions for the self-test serial link.
// Covers the receiver state encoding, the frame geometry and the parity polarity.
package self_test_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_BITS = 32;
  // Bits that follow the start bit: 32 data bits, then parity, then stop.
  localparam int FRAME_BITS = 34;
  // 1'b0 selects even parity, so the parity bit is the plain XOR of the data bits.
  localparam logic PARITY_ODD = 1'b0;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/self_test_rx_sync2.sv
// Two-flop synchronizer for the incoming serial line.
// It resets to 1, which is the idle level of the line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/self_test_rx.sv
// Receiver for the serial self-test stream: start bit, 32 data bits (LSB first),
// an even-parity bit and a stop bit. Good words are counted up to 255.
//
//   state  | meaning
//   IDLE   | line idle; waiting for a start bit (or for the line to go high after a frame error)
//   START  | confirming the start bit at mid-bit
//   DATA   | shifting in 32 data bits, one per bit period
//   PARITY | capturing the parity bit
//   STOP   | sampling the stop bit and reporting the outcome
module self_test_rx
  import self_test_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  word_cnt
);

  localparam logic [7:0] TMR_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] TMR_HALF = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0] IDX_LAST = 5'(FRAME_BITS - 3);

  logic rxs;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [7:0]           timer_q, timer_d;
  logic [4:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 need_high_q, need_high_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 timer_wrap;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    need_high_d = need_high_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    fe_d        = 1'b0;
    timer_wrap  = (timer_q == TMR_LAST);

    unique case (state_q)
      ST_IDLE: begin
        // After a bad stop bit the line may still be low; a start needs a high first.
        if (need_high_q) begin
          if (rxs) need_high_d = 1'b0;
        end else if (!rxs) begin
          state_d = ST_START;
          timer_d = 8'd0;
        end
      end
      ST_START: begin
        if (timer_q == TMR_HALF) begin
          timer_d = 8'd0;
          idx_d   = 5'd0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (timer_wrap) begin
          timer_d        = 8'd0;
          shift_d[idx_q] = rxs;
          if (idx_q == IDX_LAST) begin
            idx_d   = 5'd0;
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_PARITY: begin
        if (timer_wrap) begin
          timer_d = 8'd0;
          par_d   = rxs;
          state_d = ST_STOP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_STOP: begin
        if (timer_wrap) begin
          timer_d = 8'd0;
          state_d = ST_IDLE;
          if (!rxs) begin
            fe_d        = 1'b1;
            need_high_d = 1'b1;
          end else if (par_q == parity_of(shift_q)) begin
            dv_d   = 1'b1;
            data_d = shift_q;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else begin
            pe_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= 8'd0;
      idx_q       <= 5'd0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      need_high_q <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      need_high_q <= need_high_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
      cnt_q       <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign word_cnt   = cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_self_test_rx.sv
// Self-checking bench for self_test_rx: expected outcomes are queued when a frame
// is sent, and a monitor pops and compares them whenever the receiver pulses.
module tb_self_test_rx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_in = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;
  logic [7:0]  word_cnt;

  always #20 clk = ~clk;

  self_test_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  // kind: 0 = good word, 1 = parity error, 2 = frame error
  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          dv_seen = 0;
  logic [31:0] m_data = 32'h0;
  int          m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (data_valid || parity_err || frame_err)) begin
      exp_t e;
      int   k;
      int   n;
      n = int'(data_valid) + int'(parity_err) + int'(frame_err);
      check("pulse_onehot", n, 1);
      k = data_valid ? 0 : (parity_err ? 1 : 2);
      if (data_valid) dv_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", k);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", k, e.kind);
        check("data_out", data_out, e.data);
        check("word_cnt", {24'h0, word_cnt}, {24'h0, e.cnt});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] d, input bit flip_par, input bit stop);
    exp_t e;
    if (!stop) begin
      e.kind = 2;
    end else if (flip_par) begin
      e.kind = 1;
    end else begin
      e.kind = 0;
      m_data = d;
      if (m_cnt < 255) m_cnt++;
    end
    e.data = m_data;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 32; i++) drive_bit(d[i]);
    drive_bit((^d) ^ flip_par);
    drive_bit(stop);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_data_out", data_out, 32'h0);
    check("rst_word_cnt", {24'h0, word_cnt}, 32'h0);
    check("rst_data_valid", {31'h0, data_valid}, 32'h0);
    check("rst_parity_err", {31'h0, parity_err}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          kind;
    bit          flip;
    bit          stp;

    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_bits(2);

    // Good word with parity 0
    send_frame(32'h0000_0003, 1'b0, 1'b1);
    idle_bits(1);
    drain();
    check("good_dv_count", dv_seen, 1);

    // Parity error keeps the previous word
    send_frame(32'hEAB5_BAE1, 1'b1, 1'b1);
    idle_bits(1);
    drain();
    check("parity_hold_data", data_out, 32'h0000_0003);
    check("parity_hold_cnt", {24'h0, word_cnt}, 32'h1);

    // Frame error, line stays low, then recovers
    send_frame(32'h0F0F_A5A5, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle_bits(2);
    send_frame(32'hA5A5_0F0F, 1'b0, 1'b1);
    idle_bits(1);
    drain();
    check("after_fe_data", data_out, 32'hA5A5_0F0F);

    // One-clock glitch in idle
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (CPB + 3) @(posedge clk);
    @(negedge clk);
    check("glitch_busy", {31'h0, busy}, 32'h0);
    idle_bits(1);

    // Random mix of outcomes and gaps
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 9));
      d    = $urandom;
      flip = (kind == 6 || kind == 7);
      stp  = (kind < 8);
      send_frame(d, flip, stp);
      idle_bits(stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    idle_bits(1);
    drain();

    // Reset after 10 data bits
    drive_bit(1'b0);
    d = 32'h1234_5678;
    for (int i = 0; i < 10; i++) drive_bit(d[i]);
    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    m_data  = 32'h0;
    m_cnt   = 0;
    dv_seen = 0;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_bits(1);
    send_frame(32'h1234_5678, 1'b0, 1'b1);
    idle_bits(1);
    drain();
    check("rst_frame_dv_count", dv_seen, 1);
    check("rst_frame_cnt", {24'h0, word_cnt}, 32'h1);
    check("rst_frame_data", data_out, 32'h1234_5678);

    // Back-to-back frames through saturation
    dv_seen = 0;
    for (int n = 0; n < 260; n++) send_frame($urandom, 1'b0, 1'b1);
    idle_bits(1);
    drain();
    check("b2b_dv_count", dv_seen, 260);
    check("b2b_word_cnt", {24'h0, word_cnt}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
